// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: clear-FSM state
// encoding and the default geometry.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode-side bus of the register file: two read ports, one write port,
// issue port for the busy scoreboard and the clear request.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS
) ();

  localparam int SELW = $clog2(NREGS);

  logic [SELW-1:0]  rd1_sel;
  logic [SELW-1:0]  rd2_sel;
  logic [WIDTH-1:0] rd1_data;
  logic [WIDTH-1:0] rd2_data;
  logic             rd1_busy;
  logic             rd2_busy;
  logic             wr_en;
  logic [SELW-1:0]  wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             iss_en;
  logic [SELW-1:0]  iss_sel;
  logic             clr_req;
  logic             clr_busy;
  logic             err;

  modport master (
    output rd1_sel, rd2_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel, clr_req,
    input  rd1_data, rd2_data, rd1_busy, rd2_busy, clr_busy, err
  );

  modport slave (
    input  rd1_sel, rd2_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel, clr_req,
    output rd1_data, rd2_data, rd1_busy, rd2_busy, clr_busy, err
  );

endinterface

// File: rtl/reg_n.sv
// One register-file entry: WIDTH-bit flop with load enable and a synchronous
// clear that takes priority over the load.
module reg_n #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: each entry is a discrete flop, not RAM, so resetting it is legal and
  // cheap; sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass, per-entry busy
// scoreboard and a one-entry-per-cycle clear engine.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam int SELW = $clog2(NREGS);

  function automatic logic in_range(input logic [SELW-1:0] sel);
    return int'(sel) < NREGS;
  endfunction

  logic [WIDTH-1:0] w_q [NREGS];
  logic [NREGS-1:0] r_busy;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [SELW-1:0]  r_idx;
  logic [SELW-1:0]  w_idx_nxt;
  logic             w_idle;
  logic             w_clearing;
  logic             w_rd1_ok;
  logic             w_rd2_ok;
  logic             w_wr_in;
  logic             w_iss_in;
  logic             w_wr_ok;
  logic             w_iss_ok;
  logic             w_byp1;
  logic             w_byp2;
  logic [WIDTH-1:0] w_arr1;
  logic [WIDTH-1:0] w_arr2;
  logic             w_b1;
  logic             w_b2;

  assign w_rd1_ok = in_range(bus.rd1_sel);
  assign w_rd2_ok = in_range(bus.rd2_sel);
  assign w_wr_in  = in_range(bus.wr_sel);
  assign w_iss_in = in_range(bus.iss_sel);
  assign w_wr_ok  = bus.wr_en  & w_wr_in  & w_idle;
  assign w_iss_ok = bus.iss_en & w_iss_in & w_idle;

  // w_wr_ok is already low while clearing, which disables bypass there too
  assign w_byp1 = w_wr_ok & (bus.wr_sel == bus.rd1_sel);
  assign w_byp2 = w_wr_ok & (bus.wr_sel == bus.rd2_sel);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      reg_n #(.WIDTH(WIDTH)) u_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_wr_ok && (bus.wr_sel == SELW'(gi))),
        .i_clr  (w_clearing && (r_idx == SELW'(gi))),
        .i_d    (bus.wr_data),
        .o_q    (w_q[gi])
      );
    end
  endgenerate

  // Clear FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (bus.clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (r_idx == SELW'(NREGS - 1)) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + SELW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    w_clearing = (r_state == ST_CLEAR);
  end

  // Issue is applied after writeback so a same-cycle issue leaves the entry busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_clearing && (r_idx == SELW'(i))) begin
          r_busy[i] <= 1'b0;
        end else if (w_iss_ok && (bus.iss_sel == SELW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_wr_ok && (bus.wr_sel == SELW'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Out-of-range selects match no entry and fall through to zero
  always_comb begin
    w_arr1 = '0;
    w_arr2 = '0;
    w_b1   = 1'b0;
    w_b2   = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.rd1_sel == SELW'(i)) begin
        w_arr1 = w_q[i];
        w_b1   = r_busy[i];
      end
      if (bus.rd2_sel == SELW'(i)) begin
        w_arr2 = w_q[i];
        w_b2   = r_busy[i];
      end
    end
  end

  assign bus.rd1_data = w_byp1 ? bus.wr_data : w_arr1;
  assign bus.rd2_data = w_byp2 ? bus.wr_data : w_arr2;
  assign bus.rd1_busy = w_rd1_ok & (w_clearing | (w_b1 & ~w_byp1));
  assign bus.rd2_busy = w_rd2_ok & (w_clearing | (w_b2 & ~w_byp2));
  assign bus.clr_busy = w_clearing;
  assign bus.err      = (bus.wr_en  & ~(w_wr_in  & w_idle))
                      | (bus.iss_en & ~(w_iss_in & w_idle))
                      | ~w_rd1_ok | ~w_rd2_ok;

endmodule
